user_stream_fifo: RTL and testbench
===================================

// Module: user_stream_fifo
// PURPOSE
//  Elastic FIFO between leaf_interface user-side output (dout_leaf_interface2user/vld/ack)
//  and a user_kernel HLS input stream (Input_x_V_V/_ap_vld/_ap_ack) inside a page wrapper.
//  Decouples the kernel's ap_ack timing from the interface and absorbs bursts up to 2**DEPTH_BITS words.
//  First-word-fall-through; exposes occupancy and a delivered-word counter for debug/ILA.
// PARAMETERS
//  PAYLOAD_BITS  32  width of one stream word (matches leaf_interface PAYLOAD_BITS)
//  DEPTH_BITS    4   log2 of FIFO depth; depth = 2**DEPTH_BITS words (16)
//  CNT_BITS      32  width of delivered-word counter
// PORTS
//  clk        in   1               single clock, all state on rising edge
//  reset      in   1               asynchronous, active-high reset
//  din        in   PAYLOAD_BITS    word from leaf_interface (dout_leaf_interface2user)
//  din_vld    in   1               din valid (vld_interface2user)
//  din_ack    out  1               FIFO accepts din this cycle (to ack_user2interface)
//  dout       out  PAYLOAD_BITS    head word to user_kernel Input_x_V_V
//  dout_vld   out  1               head word valid (Input_x_V_V_ap_vld)
//  dout_ack   in   1               kernel consumes head word (Input_x_V_V_ap_ack)
//  count      out  DEPTH_BITS+1    words currently stored, 0..2**DEPTH_BITS
//  xfer_cnt   out  CNT_BITS        total words delivered on dout since reset
// BEHAVIOUR
//  - Transfer rule, both sides: word moves in a cycle where vld && ack are both 1 at the clock edge.
//    ack asserted with vld=0 is a no-op; vld may be held across cycles without ack, data held stable.
//  - Storage: register array mem[0..DEPTH-1], not reset. wr_ptr/rd_ptr are DEPTH_BITS+1 bits;
//    low DEPTH_BITS bits index mem, MSB is the wrap bit. Pointers increment mod 2**(DEPTH_BITS+1).
//  - empty = (wr_ptr == rd_ptr); full = (low bits equal) && (MSBs differ).
//  - din_ack = !full, derived from registered state only; no combinational path dout_ack -> din_ack.
//  - push = din_vld && din_ack: mem[wr_ptr] <= din, wr_ptr++.
//  - pop = dout_vld && dout_ack: rd_ptr++, xfer_cnt++ (wraps at 2**CNT_BITS to 0, no saturation).
//  - dout_vld = !empty; dout = empty ? 0 : mem[rd_ptr low bits] (combinational read of registers).
//  - Latency: word pushed at edge N is visible on dout/dout_vld after edge N (cycle N+1) when FIFO was empty.
//    Throughput: 1 word/cycle each side simultaneously.
//  - count = wr_ptr - rd_ptr (mod 2**(DEPTH_BITS+1)); registered pointers, so count updates after the edge.
//  - Simultaneous push & pop when non-empty and non-full: both occur, count unchanged.
//  - Empty: pop impossible (dout_vld=0); push with dout_ack=1 same cycle does not bypass, word appears next cycle.
//  - Full: din_ack=0 even if dout_ack=1 that cycle; pop proceeds, din_ack returns to 1 next cycle.
//  - Pointer wrap: after 2**DEPTH_BITS pushes low bits return to 0, MSB toggles; order preserved.
//  - Reset (asynchronous, any time incl. mid-burst): wr_ptr=0, rd_ptr=0, xfer_cnt=0 immediately;
//    outputs: din_ack=1, dout_vld=0, dout=0, count=0, xfer_cnt=0. Stored words are discarded.
//    First push allowed at the first rising edge after reset deasserts.
// TESTING
//  1 Reset: assert reset mid-cycle with 5 words stored -> dout_vld=0, count=0, din_ack=1, xfer_cnt=0 without a clock edge.
//  2 Single word: push 32'hDEADBEEF with dout_ack=0 -> next cycle dout_vld=1, dout=DEADBEEF, count=1; hold 3 cycles stable;
//    then dout_ack=1 -> count=0, xfer_cnt=1.
//  3 Fill: push 0..15 with dout_ack=0 -> count=16, din_ack=0; 17th word (din_vld=1, value 16) not accepted, count stays 16.
//  4 Full + pop: from full, dout_ack=1 one cycle with din_vld=1 -> that cycle no push; next cycle din_ack=1, push 16 accepted;
//    draining yields 1..16 in order.
//  5 Streaming/wrap: 40 words, din_vld=1 and dout_ack=1 continuously -> after first-word latency one word/cycle,
//    count stays 1, output sequence 0..39 exact, xfer_cnt=40.
//  6 Random: random din_vld/dout_ack (50%) over 1000 words vs scoreboard -> no loss/dup/reorder,
//    count always 0..16, din_ack==(count!=16).

Source files
------------

// File: rtl/user_stream_fifo.sv
// user_stream_fifo: first-word-fall-through elastic FIFO between the leaf interface and a user kernel stream,
// with occupancy and delivered-word counters for debug.
module user_stream_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic [DEPTH_BITS:0]     count,
    output logic [CNT_BITS-1:0]     xfer_cnt
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop;
    // Wrap bit distinguishes full from empty when the index bits match.
    always_comb begin
        empty    = wr_ptr == rd_ptr;
        full     = (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]) && (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);
        din_ack  = !full;
        dout_vld = !empty;
        push     = din_vld && din_ack;
        pop      = dout_vld && dout_ack;
        dout     = empty ? '0 : mem[rd_ptr[DEPTH_BITS-1:0]];
        count    = wr_ptr - rd_ptr;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            xfer_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_user_stream_fifo.sv
// tb_user_stream_fifo: scenario tasks checked against a queue-based model of a 16-deep FIFO.
module tb_user_stream_fifo;
    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] din = 0;
    logic        din_vld = 0;
    logic        din_ack;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_ack = 0;
    logic [4:0]  count;
    logic [31:0] xfer_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    logic [31:0] xfers = 0;

    user_stream_fifo dut (
        .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .din_ack(din_ack),
        .dout(dout), .dout_vld(dout_vld), .dout_ack(dout_ack), .count(count), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, applying the transfer rules to the model.
    task automatic cycle();
        bit push, pop;
        push = din_vld && q.size() < 16;
        pop  = dout_ack && q.size() > 0;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            xfers++;
        end
        if (push) q.push_back(din);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        #1;
        total++; if (count !== 5'd0 || din_ack !== 1'b1 || dout_vld !== 1'b0 || dout !== 32'd0) begin
            bad++; $display("FAIL reset_init count=%0d din_ack=%b dout_vld=%b dout=%h want 0/1/0/0", count, din_ack, dout_vld, dout);
        end
        din_vld = 1;
        for (int i = 0; i < 6; i++) begin
            din = 32'h100 + i;
            cycle();
        end
        din_vld = 0;
        dout_ack = 1;
        cycle();
        dout_ack = 0;
        total++; if (count !== 5'd5 || xfer_cnt !== 32'd1) begin
            bad++; $display("FAIL reset_prefill count=%0d xfer=%0d want 5/1", count, xfer_cnt);
        end
        #3 reset = 1;
        #1;
        total++; if (count !== 5'd0 || din_ack !== 1'b1 || dout_vld !== 1'b0 || dout !== 32'd0 || xfer_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_async count=%0d din_ack=%b dout_vld=%b dout=%h xfer=%0d want 0/1/0/0/0",
                            count, din_ack, dout_vld, dout, xfer_cnt);
        end
        q.delete();
        xfers = 0;
        @(posedge clk);
        @(negedge clk) reset = 0;
        #1;
    endtask

    task automatic test_single();
        din = 32'hDEADBEEF;
        din_vld = 1;
        dout_ack = 1;
        total++; if (dout_vld !== 1'b0) begin
            bad++; $display("FAIL single_empty dout_vld=%b want 0", dout_vld);
        end
        cycle();
        din_vld = 0;
        dout_ack = 0;
        for (int i = 0; i < 3; i++) begin
            total++; if (dout_vld !== 1'b1 || dout !== 32'hDEADBEEF || count !== 5'd1) begin
                bad++; $display("FAIL single_hold%0d dout_vld=%b dout=%h count=%0d want 1/deadbeef/1", i, dout_vld, dout, count);
            end
            cycle();
        end
        dout_ack = 1;
        cycle();
        dout_ack = 0;
        total++; if (count !== 5'd0 || dout_vld !== 1'b0 || xfer_cnt !== 32'd1) begin
            bad++; $display("FAIL single_pop count=%0d dout_vld=%b xfer=%0d want 0/0/1", count, dout_vld, xfer_cnt);
        end
    endtask

    task automatic test_fill();
        din_vld = 1;
        for (int i = 0; i < 16; i++) begin
            din = i;
            cycle();
        end
        total++; if (count !== 5'd16 || din_ack !== 1'b0 || dout !== 32'd0) begin
            bad++; $display("FAIL fill_full count=%0d din_ack=%b dout=%h want 16/0/0", count, din_ack, dout);
        end
        din = 16;
        cycle();
        total++; if (count !== 5'd16 || din_ack !== 1'b0 || dout !== 32'd0) begin
            bad++; $display("FAIL fill_reject count=%0d din_ack=%b dout=%h want 16/0/0", count, din_ack, dout);
        end
    endtask

    task automatic test_full_pop();
        dout_ack = 1;
        total++; if (din_ack !== 1'b0) begin
            bad++; $display("FAIL fullpop_noack din_ack=%b want 0", din_ack);
        end
        cycle();
        dout_ack = 0;
        total++; if (count !== 5'd15 || din_ack !== 1'b1) begin
            bad++; $display("FAIL fullpop_after count=%0d din_ack=%b want 15/1", count, din_ack);
        end
        cycle();
        din_vld = 0;
        total++; if (count !== 5'd16) begin
            bad++; $display("FAIL fullpop_push16 count=%0d want 16", count);
        end
        dout_ack = 1;
        for (int i = 1; i <= 16; i++) begin
            total++; if (dout !== 32'(i) || dout_vld !== 1'b1) begin
                bad++; $display("FAIL drain_%0d dout=%0d vld=%b want %0d/1", i, dout, dout_vld, i);
            end
            cycle();
        end
        dout_ack = 0;
        total++; if (count !== 5'd0 || xfer_cnt !== xfers) begin
            bad++; $display("FAIL drain_end count=%0d xfer=%0d want 0/%0d", count, xfer_cnt, xfers);
        end
    endtask

    task automatic test_stream();
        logic [31:0] x0;
        x0 = xfer_cnt;
        din_vld = 1;
        dout_ack = 1;
        for (int i = 0; i < 40; i++) begin
            din = i;
            if (i > 0) begin
                total++; if (count !== 5'd1 || dout !== 32'(i - 1) || din_ack !== 1'b1) begin
                    bad++; $display("FAIL stream_%0d count=%0d dout=%0d din_ack=%b want 1/%0d/1", i, count, dout, din_ack, i - 1);
                end
            end
            cycle();
        end
        din_vld = 0;
        total++; if (dout !== 32'd39 || count !== 5'd1) begin
            bad++; $display("FAIL stream_last dout=%0d count=%0d want 39/1", dout, count);
        end
        cycle();
        dout_ack = 0;
        total++; if (count !== 5'd0 || xfer_cnt - x0 !== 32'd40) begin
            bad++; $display("FAIL stream_end count=%0d delivered=%0d want 0/40", count, xfer_cnt - x0);
        end
    endtask

    task automatic test_random();
        int sent, cyc;
        logic [31:0] x0;
        sent = 0;
        cyc = 0;
        x0 = xfers;
        while (xfers - x0 < 1000 && cyc < 20000) begin
            din_vld = (sent < 1000) && ($urandom % 2 == 1);
            din = $urandom;
            dout_ack = $urandom % 2 == 1;
            total++; if (count !== 5'(q.size()) || din_ack !== (q.size() != 16) || dout_vld !== (q.size() != 0)) begin
                bad++; $display("FAIL rand_state cyc=%0d count=%0d din_ack=%b dout_vld=%b want %0d/%b/%b",
                                cyc, count, din_ack, dout_vld, q.size(), q.size() != 16, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++; if (dout !== q[0]) begin
                    bad++; $display("FAIL rand_data cyc=%0d dout=%h want %h", cyc, dout, q[0]);
                end
            end
            if (din_vld && q.size() < 16) sent++;
            cycle();
            cyc++;
        end
        din_vld = 0;
        dout_ack = 0;
        total++; if (xfers - x0 != 1000) begin
            bad++; $display("FAIL rand_timeout delivered=%0d want 1000", xfers - x0);
        end
        total++; if (xfer_cnt !== xfers) begin
            bad++; $display("FAIL rand_xfer xfer=%0d want %0d", xfer_cnt, xfers);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
